// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

   localparam int WIDTH = 32;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;

   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;

   function automatic logic is_muldiv(input logic [5:0] f);
      return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
   endfunction

   function automatic logic is_hilo(input logic [5:0] f);
      return is_muldiv(f) || (f == F_MTHI) || (f == F_MTLO) ||
             (f == F_MFHI) || (f == F_MFLO);
   endfunction

endpackage

// File: rtl/muldiv_core.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide, one bit per step.
module muldiv_core
   import muldiv_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_load,
   input  logic                 i_step,
   input  logic                 i_mode,
   input  logic [WIDTH-1:0]     i_a,
   input  logic [WIDTH-1:0]     i_b,
   output logic [2*WIDTH-1:0]   o_acc
);

   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH:0]     w_madd;
   logic [WIDTH:0]     w_cand;
   logic [WIDTH:0]     w_dsub;
   logic               w_ge;
   logic [2*WIDTH-1:0] w_acc_nxt;

   // Multiply: upper half accumulates, multiplier shifts out of the lower half.
   // Divide: upper half is the partial remainder, quotient bits shift into the bottom.
   assign w_madd = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
   assign w_cand = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_dsub = w_cand - {1'b0, r_b};
   assign w_ge   = (w_cand >= {1'b0, r_b});

   always_comb begin
      w_acc_nxt = r_acc;
      if (i_mode)
         w_acc_nxt = {(w_ge ? w_dsub[WIDTH-1:0] : w_cand[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};
      else
         w_acc_nxt = {w_madd, r_acc[WIDTH-1:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_b   <= '0;
      end else if (i_load) begin
         r_acc <= {{WIDTH{1'b0}}, i_a};
         r_b   <= i_b;
      end else if (i_step) begin
         r_acc <= w_acc_nxt;
      end
   end

   assign o_acc = r_acc;

endmodule

// File: rtl/muldiv_seq.sv
// HI/LO multiply/divide sequencer: decode, FSM, sign handling, HI/LO and stall.
//  state | meaning
//  IDLE  | accepting ops, mthi/mtlo write HI/LO directly
//  CALC  | 32 magnitude steps in muldiv_core
//  FIX   | sign correction, HI/LO written on exit
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int WIDTH = muldiv_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid,
   input  logic [5:0]       opcode,
   input  logic [5:0]       func,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             flush,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [1:0]         r_state;
   logic [4:0]         r_cnt;
   logic               r_sa, r_sb, r_div, r_div0, r_done;
   logic [WIDTH-1:0]   r_hi, r_lo;

   logic               w_live, w_accept, w_signed, w_sa, w_sb, w_neg;
   logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_quo, w_rem, w_res_hi, w_res_lo;
   logic [2*WIDTH-1:0] w_acc, w_prod;

   assign w_live   = valid && !flush && (opcode == OP_SPECIAL);
   assign w_accept = (r_state == ST_IDLE) && w_live && is_muldiv(func);
   assign w_signed = (func == F_MULT) || (func == F_DIV);
   assign w_sa     = w_signed && op_a[WIDTH-1];
   assign w_sb     = w_signed && op_b[WIDTH-1];
   assign w_mag_a  = w_sa ? -op_a : op_a;
   assign w_mag_b  = w_sb ? -op_b : op_b;

   muldiv_core u_core (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_accept),
      .i_step (r_state == ST_CALC),
      .i_mode (r_div),
      .i_a    (w_mag_a),
      .i_b    (w_mag_b),
      .o_acc  (w_acc)
   );

   // Divide by zero leaves remainder = |a|, which sign-corrects back to op_a;
   // only the quotient needs forcing to all ones.
   assign w_neg    = r_sa ^ r_sb;
   assign w_prod   = w_neg ? -w_acc : w_acc;
   assign w_quo    = r_div0 ? '1 : (w_neg ? -w_acc[WIDTH-1:0] : w_acc[WIDTH-1:0]);
   assign w_rem    = r_sa ? -w_acc[2*WIDTH-1:WIDTH] : w_acc[2*WIDTH-1:WIDTH];
   assign w_res_hi = r_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
   assign w_res_lo = r_div ? w_quo : w_prod[WIDTH-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_sa    <= 1'b0;
         r_sb    <= 1'b0;
         r_div   <= 1'b0;
         r_div0  <= 1'b0;
         r_done  <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state <= ST_CALC;
                  r_cnt   <= '0;
                  r_sa    <= w_sa;
                  r_sb    <= w_sb;
                  r_div   <= func[1];
                  r_div0  <= func[1] && (op_b == '0);
               end else if (w_live && func == F_MTHI) begin
                  r_hi <= op_a;
               end else if (w_live && func == F_MTLO) begin
                  r_lo <= op_a;
               end
            end
            ST_CALC: begin
               if (flush) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + 5'd1;
                  if (r_cnt == 5'd31)
                     r_state <= ST_FIX;
               end
            end
            ST_FIX: begin
               r_state <= ST_IDLE;
               if (!flush) begin
                  r_hi   <= w_res_hi;
                  r_lo   <= w_res_lo;
                  r_done <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy  = (r_state != ST_IDLE);
   assign stall = valid && !flush && busy && (opcode == OP_SPECIAL) && is_hilo(func);
   assign done  = r_done;
   assign hi    = r_hi;
   assign lo    = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench: behavioural HI/LO model compared every cycle, plus literal pins.
module tb_muldiv_seq;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0;
   logic [5:0]  opcode = 6'd0;
   logic [5:0]  func = 6'd0;
   logic [31:0] op_a = 32'd0;
   logic [31:0] op_b = 32'd0;
   logic        flush = 1'b0;
   logic        stall, busy, done;
   logic [31:0] hi, lo;

   int n_tot = 0;
   int n_pass = 0;

   muldiv_seq #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .valid(valid), .opcode(opcode), .func(func),
      .op_a(op_a), .op_b(op_b), .flush(flush), .stall(stall), .busy(busy),
      .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      else n_pass++;
   endtask

   // Reference result {hi, lo} from plain arithmetic.
   function automatic logic [63:0] ref_res(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
      longint sa, sb, q, r;
      longint unsigned ua, ub;
      logic [63:0] p;
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      ua = {32'd0, a};
      ub = {32'd0, b};
      if ((f == F_DIV || f == F_DIVU) && b == 32'd0) return {a, 32'hFFFFFFFF};
      case (f)
         F_MULT:  begin q = sa * sb; p = q; end
         F_MULTU: p = ua * ub;
         F_DIV:   begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
         default: begin p = {32'(ua % ub), 32'(ua / ub)}; end
      endcase
      return p;
   endfunction

   function automatic logic is_md(input logic [5:0] f);
      return f == F_MULT || f == F_MULTU || f == F_DIV || f == F_DIVU;
   endfunction

   function automatic logic is_hl(input logic [5:0] f);
      return is_md(f) || f == F_MTHI || f == F_MTLO || f == F_MFHI || f == F_MFLO;
   endfunction

   // Model: remaining busy cycles, committed HI/LO, pending result, done flag.
   int          m_rem = 0;
   logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
   logic        m_done = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_rem = 0; m_hi = 0; m_lo = 0; m_done = 0;
      end else begin
         m_done = 0;
         if (m_rem > 0) begin
            if (flush) m_rem = 0;
            else begin
               m_rem--;
               if (m_rem == 0) begin
                  m_hi = m_phi; m_lo = m_plo; m_done = 1;
               end
            end
         end else if (valid && !flush && opcode == 6'd0) begin
            if (is_md(func)) begin
               {m_phi, m_plo} = ref_res(func, op_a, op_b);
               m_rem = 33;
            end else if (func == F_MTHI) m_hi = op_a;
            else if (func == F_MTLO) m_lo = op_a;
         end
      end
   end

   always @(negedge clk) begin
      logic exp_stall;
      exp_stall = valid && !flush && (m_rem > 0) && opcode == 6'd0 && is_hl(func);
      chk("cyc_busy",  64'(busy),  64'(m_rem > 0));
      chk("cyc_done",  64'(done),  64'(m_done));
      chk("cyc_stall", 64'(stall), 64'(exp_stall));
      chk("cyc_hi",    64'(hi),    64'(m_hi));
      chk("cyc_lo",    64'(lo),    64'(m_lo));
   end

   task automatic present(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      valid = 1'b1; opcode = 6'd0; func = f; op_a = a; op_b = b;
   endtask

   task automatic idle_in();
      valid = 1'b0; func = 6'd0; op_a = 0; op_b = 0; flush = 1'b0;
   endtask

   task automatic run_op(input string nm, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
      int nb, nd;
      nb = 0; nd = 0;
      present(f, a, b);
      @(posedge clk); #1 idle_in();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy) nb++;
         if (done) nd++;
      end
      chk({nm, "_busy_cycles"}, 64'(nb), 64'd33);
      chk({nm, "_done_pulses"}, 64'(nd), 64'd1);
      chk({nm, "_hi"}, 64'(hi), 64'(eh));
      chk({nm, "_lo"}, 64'(lo), 64'(el));
      @(posedge clk); #1;
   endtask

   initial begin
      int ns, nd;
      logic [5:0] fl [8];
      logic [31:0] corner [5];
      fl = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO, F_MFHI, F_MFLO};
      corner = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

      #12;
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_hilo", {hi, lo}, 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      // model pins
      chk("model_mult", ref_res(F_MULT, 32'hFFFFFFFD, 32'd5), 64'hFFFFFFFF_FFFFFFF1);
      chk("model_ovf", ref_res(F_DIV, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);

      run_op("multu", F_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE);
      run_op("mult", F_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
      run_op("div", F_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("divu0", F_DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF);
      run_op("div0s", F_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
      run_op("divovf", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);

      // mthi/mtlo back-to-back
      present(F_MTHI, 32'h1234, 0);
      @(negedge clk); chk("mthi_stall", 64'(stall), 64'd0);
      @(posedge clk); #1 present(F_MTLO, 32'h5678, 0);
      @(negedge clk); chk("mtlo_stall", 64'(stall), 64'd0);
      @(posedge clk); #1 idle_in();
      @(negedge clk);
      chk("mt_hi", 64'(hi), 64'h1234);
      chk("mt_lo", 64'(lo), 64'h5678);

      // mflo held behind a mult
      @(posedge clk); #1 present(F_MULT, 32'd7, 32'hFFFFFFFA);
      @(posedge clk); #1 idle_in();
      @(posedge clk); #1 present(F_MFLO, 0, 0);
      ns = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!stall) break;
         ns++;
      end
      chk("mflo_stall_cycles", 64'(ns), 64'd32);
      chk("mflo_done", 64'(done), 64'd1);
      chk("mflo_lo", 64'(lo), 64'hFFFFFFD6);
      chk("mflo_hi", 64'(hi), 64'hFFFFFFFF);
      @(posedge clk); #1 idle_in();

      // flush at CALC cycle 10
      present(F_MTHI, 32'hAAAA0001, 0);
      @(posedge clk); #1 present(F_MTLO, 32'h5555000F, 0);
      @(posedge clk); #1 present(F_MULTU, 32'd1000, 32'd1000);
      @(posedge clk); #1 idle_in();
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk); chk("flush_busy", 64'(busy), 64'd0);
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("flush_no_done", 64'(nd), 64'd0);
      chk("flush_hilo", {hi, lo}, 64'hAAAA0001_5555000F);

      // reset at CALC cycle 10 with a held mfhi
      @(posedge clk); #1 present(F_DIVU, 32'd100, 32'd7);
      @(posedge clk); #1 present(F_MFHI, 0, 0);
      repeat (9) @(posedge clk);
      @(negedge clk); chk("pre_rst_stall", 64'(stall), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_busy", 64'(busy), 64'd0);
      chk("rst_mid_stall", 64'(stall), 64'd0);
      chk("rst_mid_done", 64'(done), 64'd0);
      chk("rst_mid_hilo", {hi, lo}, 64'd0);
      idle_in();
      @(posedge clk); #1 rst_n = 1'b1;

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk); #1;
         valid  = ($urandom_range(0, 3) != 0);
         opcode = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
         func   = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fl[$urandom_range(0, 7)];
         op_a   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         op_b   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] :
                  (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 300)) : $urandom);
         flush  = ($urandom_range(0, 39) == 0);
      end
      @(posedge clk); #1 idle_in();
      repeat (40) @(posedge clk);
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port valid  input  1  EX-stage instruction valid.
REQ-005 SHALL have port opcode  input  6  EX-stage opcode.
REQ-006 SHALL have port func  input  6  EX-stage funct field.
REQ-007 SHALL have port op_a  input  32  first operand from the ALU operand-source stage (rs value).
REQ-008 SHALL have port op_b  input  32  second operand from the ALU operand-source stage (rt value).
REQ-009 SHALL have port flush  input  1  squash of the EX-stage instruction and any op in flight.
REQ-010 SHALL have port stall  output  1  combinational pipeline hold request.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse after HI/LO are written by mult/div.
REQ-013 SHALL have port hi  output  32  current HI register.
REQ-014 SHALL have port lo  output  32  current LO register.

Function
REQ-015 SHALL decode, only when opcode == 0: mult 011000, multu 011001, div 011010, divu 011011, mthi 010001, mtlo 010011, mfhi 010000, mflo 010010; all other encodings are ignored.
REQ-016 SHALL implement states IDLE, CALC and FIX.
REQ-017 SHALL accept mult/multu/div/divu only in IDLE with valid=1 and flush=0: capture operand magnitudes and signs, clear a 5-bit iteration counter, and go to CALC.
REQ-018 SHALL perform one shift-add (multiply) or restoring-subtract (divide) step per CALC cycle, 32 steps total, then go to FIX.
REQ-019 SHALL apply signed correction in FIX (negate product if signs differ; quotient sign = sign_a XOR sign_b; remainder sign = sign_a), write HI/LO on the FIX->IDLE edge, and pulse done for the following cycle.
REQ-020 SHALL keep busy high for exactly 33 cycles per accepted op; HI/LO update on the 33rd rising edge after the acceptance edge.
REQ-021 SHALL produce HI:LO = 64-bit product for multiply, and LO = quotient, HI = remainder for divide.
REQ-022 SHALL, on divide by zero, complete with normal latency and write LO = 0xFFFFFFFF, HI = op_a.
REQ-023 SHALL, for signed 0x80000000 / 0xFFFFFFFF, write LO = 0x80000000, HI = 0.
REQ-024 SHALL execute mthi/mtlo in IDLE by writing op_a to HI/LO on the next edge, with no busy.
REQ-025 SHALL assert stall = valid AND NOT flush AND (state != IDLE) AND (op is any of the 8 HI/LO instructions); the requester holds the instruction until stall drops.
REQ-026 SHALL ignore new ops while not in IDLE; they are neither queued nor lost, because stall holds them.
REQ-027 SHALL, on flush in CALC or FIX, return to IDLE on the next edge with HI/LO unchanged and no done pulse.
REQ-028 SHALL give flush priority over acceptance when both apply in the same cycle.
REQ-029 SHALL drive hi/lo directly from the registers; mfhi/mflo read them once stall is low.

Reset
REQ-030 SHALL, on rst_n low (asynchronously, including mid-operation), force state=IDLE, counter=0, HI=0, LO=0, done=0 and busy=0; stall becomes 0.
REQ-031 SHALL leave IDLE on the first rising edge after rst_n deasserts only if an op is accepted.

Structure
REQ-032 SHALL place the funct codes, the state enum and WIDTH in the shared package muldiv_pkg.
REQ-033 SHALL contain a single sub-module, muldiv_core: an iterative magnitude datapath with step and mode inputs and 64-bit accumulator outputs. muldiv_seq owns the FSM, sign handling, HI/LO and stall.

Verification
REQ-034 SHALL check: multu 0xFFFFFFFF x 2 -> HI=0x00000001, LO=0xFFFFFFFE on edge 33; done pulses once.
REQ-035 SHALL check: mult -3 x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; div -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-036 SHALL check: divu 9 / 0 -> LO=0xFFFFFFFF, HI=9 after 33 cycles.
REQ-037 SHALL check: mflo presented one cycle after mult is accepted -> stall high for 32 cycles, low in the done cycle, and mflo sees the new LO.
REQ-038 SHALL check: flush at CALC cycle 10 -> IDLE next edge, HI/LO keep prior values, no done; likewise for rst_n low at CALC cycle 10 -> all outputs 0 immediately.
REQ-039 SHALL check: mthi 0x1234 then mtlo 0x5678 back-to-back in IDLE -> hi=0x1234, lo=0x5678, stall never asserted.
